// File: rtl/shr_pkg.sv
// shr_pkg: shared defaults and the output-register state encoding for the SHR datapath stage.
package shr_pkg;
    localparam int SHR_WIDTH     = 2;
    localparam int SHR_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } shr_out_state_t;
endpackage

// File: rtl/shr_out_reg_sat_counter.sv
// sat_counter: saturating up-counter with increment enable and async active-high reset.
module sat_counter #(
    parameter int CNT_WIDTH = shr_pkg::SHR_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    assign cnt_d = (inc_i && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    assign cnt_o = cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/shr_out_reg.sv
// shr_out_reg: two-entry elastic output register for the SHR stage with a saturating transfer counter.
// Define SHR_OUT_REG_ZERO_EN to add the out_zero flag that travels with each stored word.
module shr_out_reg
    import shr_pkg::*;
#(
    parameter int WIDTH     = SHR_WIDTH,
    parameter int CNT_WIDTH = SHR_CNT_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [WIDTH-1:0]     in_d,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_d,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef SHR_OUT_REG_ZERO_EN
    output logic                 out_zero,
`endif
    output logic [CNT_WIDTH-1:0] xfer_cnt
);
    shr_out_state_t   state_q;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             acc, tk, ld_main, ld_skid, from_skid;

    // Handshake outputs decode only the state, so no input reaches them combinationally.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != TWO);
    assign out_d     = main_q;

    assign acc       = in_valid && in_ready;
    assign tk        = out_valid && out_ready;
    assign from_skid = (state_q == TWO);
    assign ld_main   = (state_q == EMPTY && acc) || (state_q == ONE && acc && tk) || (state_q == TWO && tk);
    assign ld_skid   = (state_q == ONE) && acc && !tk;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY:   state_q <= acc ? ONE : EMPTY;
                ONE:     state_q <= (acc && !tk) ? TWO : (!acc && tk) ? EMPTY : ONE;
                TWO:     state_q <= tk ? ONE : TWO;
                default: state_q <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main) main_q <= from_skid ? skid_q : in_d;
            if (ld_skid) skid_q <= in_d;
        end
    end

`ifdef SHR_OUT_REG_ZERO_EN
    logic main_z_q, skid_z_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            main_z_q <= 1'b1;
            skid_z_q <= 1'b1;
        end else begin
            if (ld_main) main_z_q <= from_skid ? skid_z_q : (in_d == '0);
            if (ld_skid) skid_z_q <= (in_d == '0);
        end
    end

    assign out_zero = main_z_q;
`endif

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_xfer_cnt (
        .clk_i (Clk),
        .rst_i (Rst),
        .inc_i (tk),
        .cnt_o (xfer_cnt)
    );
endmodule

// File: tb/tb_shr_out_reg.sv
// tb_shr_out_reg: directed and scoreboarded checks of shr_out_reg at WIDTH=8, CNT_WIDTH=4.
module tb_shr_out_reg;
    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] in_d = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_d;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_zero;
    logic [3:0] xfer_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;

    shr_out_reg #(.WIDTH(8), .CNT_WIDTH(4)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_d      (in_d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_d     (out_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SHR_OUT_REG_ZERO_EN
        .out_zero  (out_zero),
`endif
        .xfer_cnt  (xfer_cnt)
    );

`ifndef SHR_OUT_REG_ZERO_EN
    assign out_zero = (out_d == 8'h00);
`endif

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic r, input logic [7:0] d);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(r));
        check({tag, ".out_d"}, 32'(out_d), 32'(d));
    endtask

    logic [7:0] q[$];
    logic       acc, tk, stalled;
    logic [7:0] prev_d;
    int         takes;

    initial begin
        // reset values with in_valid asserted and ignored
        in_valid = 1'b1;
        in_d = 8'hAA;
        tick();
        tick();
        chk_out("rst", 1'b0, 1'b1, 8'h00);
        check("rst.cnt", 32'(xfer_cnt), 0);
        check("rst.zero", 32'(out_zero), 1);
        in_valid = 1'b0;
        Rst = 1'b0;
        tick();
        chk_out("post_rst", 1'b0, 1'b1, 8'h00);

        // streaming at full throughput
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_d = 8'hB4 >> 2;
        tick();
        chk_out("s0", 1'b1, 1'b1, 8'h2D);
        check("s0.zero", 32'(out_zero), 0);
        in_d = 8'h80 >> 7;
        tick();
        chk_out("s1", 1'b1, 1'b1, 8'h01);
        check("s1.zero", 32'(out_zero), 0);
        in_d = 8'h00;
        tick();
        chk_out("s2", 1'b1, 1'b1, 8'h00);
        check("s2.zero", 32'(out_zero), 1);
        in_valid = 1'b0;
        tick();
        check("s3.valid", 32'(out_valid), 0);
        check("s3.cnt", 32'(xfer_cnt), 3);

        // stall fills both entries and back-pressures the third word
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_d = 8'h11;
        tick();
        chk_out("st0", 1'b1, 1'b1, 8'h11);
        in_d = 8'h22;
        tick();
        chk_out("st1", 1'b1, 1'b0, 8'h11);
        in_d = 8'h33;
        tick();
        chk_out("st2", 1'b1, 1'b0, 8'h11);
        tick();
        chk_out("st3", 1'b1, 1'b0, 8'h11);
        out_ready = 1'b1;
        tick();
        chk_out("st4", 1'b1, 1'b1, 8'h22);
        tick();
        chk_out("st5", 1'b1, 1'b1, 8'h33);
        in_valid = 1'b0;
        tick();
        chk_out("st6", 1'b0, 1'b1, 8'h33);
        check("st6.cnt", 32'(xfer_cnt), 6);

        // accept and take in the same cycle while in ONE
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_d = 8'h44;
        tick();
        chk_out("sim0", 1'b1, 1'b1, 8'h44);
        in_d = 8'h55;
        out_ready = 1'b1;
        tick();
        chk_out("sim1", 1'b1, 1'b1, 8'h55);
        check("sim1.cnt", 32'(xfer_cnt), 7);

        // asynchronous reset mid-stream with two words held
        out_ready = 1'b0;
        in_d = 8'h66;
        tick();
        chk_out("pre_ar", 1'b1, 1'b0, 8'h55);
        #2 Rst = 1'b1;
        #1;
        chk_out("ar", 1'b0, 1'b1, 8'h00);
        check("ar.cnt", 32'(xfer_cnt), 0);
        in_valid = 1'b0;
        tick();
        Rst = 1'b0;

        // saturation over 20 takes
        for (int k = 1; k <= 20; k++) begin
            in_valid = 1'b1;
            out_ready = 1'b0;
            in_d = 8'(k);
            tick();
            in_valid = 1'b0;
            out_ready = 1'b1;
            tick();
            check($sformatf("sat%0d", k), 32'(xfer_cnt), (k < 15) ? k : 15);
        end
        out_ready = 1'b0;
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        tick();

        // random traffic against a queue model
        stalled = 1'b0;
        prev_d = 8'h00;
        takes = 0;
        for (int c = 0; c < 3000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            in_d = 8'($urandom);
            check("rnd.valid", 32'(out_valid), 32'(q.size() > 0));
            check("rnd.ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) check("rnd.d", 32'(out_d), 32'(q[0]));
            if (stalled) check("rnd.stable", 32'(out_d), 32'(prev_d));
            check("rnd.zero", 32'(out_zero), 32'(out_d == 8'h00));
            acc = in_valid && (q.size() < 2);
            tk = out_ready && (q.size() > 0);
            stalled = (q.size() > 0) && !out_ready;
            prev_d = out_d;
            tick();
            if (tk) begin
                void'(q.pop_front());
                takes++;
            end
            if (acc) q.push_back(in_d);
        end
        check("rnd.cnt", 32'(xfer_cnt), (takes < 15) ? takes : 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
